// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces whole-matrix
// scans and emits one strobe with a hex key code per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_FULL  = SW'(DEBOUNCE_SCANS);

  typedef enum logic {
    ARMED,
    PRESSED
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } result_t;

  logic [3:0]    rowMeta_q, rowMeta_d;
  logic [3:0]    rowSync_q, rowSync_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    colIdx_q, colIdx_d;
  logic [1:0]    hitCnt_q, hitCnt_d;
  logic [3:0]    hitCode_q, hitCode_d;
  result_t       prev_q, prev_d;
  logic [3:0]    prevCode_q, prevCode_d;
  logic [SW-1:0] stabCnt_q, stabCnt_d;
  state_t        state_q, state_d;
  logic [3:0]    keyCode_q, keyCode_d;
  logic          keyValid_q, keyValid_d;
  logic          keyHeld_q, keyHeld_d;

  logic [3:0]    rowLow;
  logic [2:0]    rowPop;
  logic [1:0]    rowIdx;

  function automatic logic [3:0] mapKey(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign rowLow = ~rowSync_q;
  assign rowPop = {2'b00, rowLow[0]} + {2'b00, rowLow[1]}
                + {2'b00, rowLow[2]} + {2'b00, rowLow[3]};

  always_comb begin
    rowIdx = 2'd0;
    if (rowLow[0])      rowIdx = 2'd0;
    else if (rowLow[1]) rowIdx = 2'd1;
    else if (rowLow[2]) rowIdx = 2'd2;
    else if (rowLow[3]) rowIdx = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rowMeta_q  <= 4'hF;
      rowSync_q  <= 4'hF;
      dwell_q    <= '0;
      colIdx_q   <= 2'd0;
      hitCnt_q   <= 2'd0;
      hitCode_q  <= 4'h0;
      prev_q     <= RES_NONE;
      prevCode_q <= 4'h0;
      stabCnt_q  <= '0;
      state_q    <= ARMED;
      keyCode_q  <= 4'h0;
      keyValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      rowMeta_q  <= rowMeta_d;
      rowSync_q  <= rowSync_d;
      dwell_q    <= dwell_d;
      colIdx_q   <= colIdx_d;
      hitCnt_q   <= hitCnt_d;
      hitCode_q  <= hitCode_d;
      prev_q     <= prev_d;
      prevCode_q <= prevCode_d;
      stabCnt_q  <= stabCnt_d;
      state_q    <= state_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyHeld_q  <= keyHeld_d;
    end
  end

  // Hit accumulation saturates at 2 so any ghost pattern collapses to MULTI.
  logic [1:0]    newCnt;
  logic [3:0]    newCode;
  logic          scanDone;
  result_t       scanRes;
  logic [SW-1:0] stabInc;

  always_comb begin
    rowMeta_d  = row;
    rowSync_d  = rowMeta_q;
    dwell_d    = dwell_q;
    colIdx_d   = colIdx_q;
    hitCnt_d   = hitCnt_q;
    hitCode_d  = hitCode_q;
    prev_d     = prev_q;
    prevCode_d = prevCode_q;
    stabCnt_d  = stabCnt_q;
    state_d    = state_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
    keyHeld_d  = keyHeld_q;
    newCnt     = hitCnt_q;
    newCode    = hitCode_q;
    scanDone   = 1'b0;
    scanRes    = RES_NONE;
    stabInc    = (stabCnt_q == STAB_FULL) ? STAB_FULL : stabCnt_q + 1'b1;

    if (dwell_q == DWELL_LAST) begin
      dwell_d  = '0;
      colIdx_d = colIdx_q + 2'd1;
      if (rowPop >= 3'd2) begin
        newCnt = 2'd2;
      end else if (rowPop == 3'd1) begin
        newCnt  = (hitCnt_q == 2'd0) ? 2'd1 : 2'd2;
        newCode = mapKey(rowIdx, colIdx_q);
      end
      if (colIdx_q == 2'd3) begin
        scanDone  = 1'b1;
        hitCnt_d  = 2'd0;
        hitCode_d = 4'h0;
        case (newCnt)
          2'd0:    scanRes = RES_NONE;
          2'd1:    scanRes = RES_SINGLE;
          default: scanRes = RES_MULTI;
        endcase
      end else begin
        hitCnt_d  = newCnt;
        hitCode_d = newCode;
      end
    end else begin
      dwell_d = dwell_q + 1'b1;
    end

    if (scanDone) begin
      case (scanRes)
        RES_NONE: begin
          if (prev_q == RES_NONE) begin
            stabCnt_d = stabInc;
          end else begin
            stabCnt_d = SW'(1);
            prev_d    = RES_NONE;
          end
        end
        RES_SINGLE: begin
          if (prev_q == RES_SINGLE && prevCode_q == newCode) begin
            stabCnt_d = stabInc;
          end else begin
            stabCnt_d  = SW'(1);
            prev_d     = RES_SINGLE;
            prevCode_d = newCode;
          end
        end
        default: begin
          stabCnt_d = '0;
          prev_d    = RES_MULTI;
        end
      endcase

      // A new key is only reported from ARMED, so a release must come first.
      case (state_q)
        ARMED: begin
          if (scanRes == RES_SINGLE && stabCnt_d == STAB_FULL) begin
            keyCode_d  = newCode;
            keyValid_d = 1'b1;
            keyHeld_d  = 1'b1;
            state_d    = PRESSED;
          end
        end
        default: begin
          if (scanRes == RES_NONE && stabCnt_d == STAB_FULL) begin
            keyHeld_d = 1'b0;
            state_d   = ARMED;
          end
        end
      endcase
    end
  end

  assign col       = ~(4'b0001 << colIdx_q);
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives row from col, expected
// key codes go into a queue that a monitor pops on every key_valid strobe.
module tb_keypad_scanner;

  logic       clk;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  logic [3:0]  expQ[$];
  int          checkCount = 0;
  int          errorCount = 0;

  localparam int SCAN = 16;

  logic [3:0] keyMap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};
  logic [3:0] colExp [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int keyIdx, input logic down);
    pressed[keyIdx] = down;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    waitCycles(3);
    reset_n = 1'b1;
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, 4'(expQ.size()), 4'h0);
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL unexpectedPulse: got key_code %h, expected no pulse at %0t", key_code, $time);
      end else begin
        checkOutput("pulseCode", key_code, expQ.pop_front());
        checkOutput("heldAtPulse", {3'b000, key_held}, 4'h1);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pressed = '0;
    reset_n = 1'b0;
    applyReset();

    // Idle: column walk every SCAN_DIV cycles, outputs at reset values.
    checkOutput("resetValid", {3'b000, key_valid}, 4'h0);
    checkOutput("resetHeld", {3'b000, key_held}, 4'h0);
    checkOutput("resetCode", key_code, 4'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("colWalk%0d", i), col, colExp[i]);
      if (i < 4) waitCycles(4);
    end
    waitCycles(3 * SCAN);
    checkOutput("idleHeld", {3'b000, key_held}, 4'h0);

    // Key 5 held 100 cycles.
    expQ.push_back(4'h5);
    applyStimulus(5, 1'b1);
    waitCycles(100);
    checkOutput("held5", {3'b000, key_held}, 4'h1);
    applyStimulus(5, 1'b0);
    waitCycles(5 * SCAN);
    checkOutput("released5", {3'b000, key_held}, 4'h0);
    checkOutput("code5Holds", key_code, 4'h5);
    checkDrained("drained5");

    // All 16 keys in sequence.
    for (int k = 0; k < 16; k++) begin
      expQ.push_back(keyMap[k]);
      applyStimulus(k, 1'b1);
      waitCycles(5 * SCAN);
      checkOutput($sformatf("heldKey%0d", k), {3'b000, key_held}, 4'h1);
      applyStimulus(k, 1'b0);
      waitCycles(5 * SCAN);
      checkOutput($sformatf("relKey%0d", k), {3'b000, key_held}, 4'h0);
    end
    checkDrained("drainedAll");

    // Ghost: keys 1 and 6 together are rejected; releasing 6 reports 1.
    pressed[0] = 1'b1;
    pressed[6] = 1'b1;
    waitCycles(5 * SCAN);
    checkOutput("ghostHeld", {3'b000, key_held}, 4'h0);
    expQ.push_back(4'h1);
    applyStimulus(6, 1'b0);
    waitCycles(5 * SCAN);
    checkOutput("after6Held", {3'b000, key_held}, 4'h1);
    applyStimulus(0, 1'b0);
    waitCycles(5 * SCAN);
    checkOutput("after1Rel", {3'b000, key_held}, 4'h0);
    checkDrained("drainedGhost");

    // Bounce on key 9, then held.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(10, (i % 2) == 0);
      waitCycles(SCAN);
    end
    checkOutput("bounceHeld", {3'b000, key_held}, 4'h0);
    expQ.push_back(4'h9);
    applyStimulus(10, 1'b1);
    waitCycles(5 * SCAN);
    checkOutput("held9", {3'b000, key_held}, 4'h1);
    applyStimulus(10, 1'b0);
    waitCycles(5 * SCAN);
    checkDrained("drainedBounce");

    // Reset just before the accepting scan of key 3 completes.
    applyReset();
    applyStimulus(2, 1'b1);
    waitCycles(30);
    reset_n = 1'b0;
    waitCycles(2);
    checkOutput("rstValid", {3'b000, key_valid}, 4'h0);
    checkOutput("rstHeld", {3'b000, key_held}, 4'h0);
    checkOutput("rstCode", key_code, 4'h0);
    checkOutput("rstCol", col, 4'b1110);
    applyStimulus(2, 1'b0);
    reset_n = 1'b1;
    waitCycles(4 * SCAN);
    checkOutput("postRstHeld", {3'b000, key_held}, 4'h0);
    checkDrained("drainedFinal");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
